// File: rtl/timebase_pkg.sv
// timebase_pkg: shared FSM state encodings and period limits for the clock timebase
package timebase_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_STEP  = 2'b11
  } state_t;
  localparam int unsigned MIN_DIV = 2;
endpackage

// File: rtl/timebase_ctrl_tick_gen.sv
// tick_gen: modulo-N counter with enable and clear, emitting a registered 1-cycle tick on wrap
module tick_gen #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] n_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, wrap;
  // >= rather than == so a period shrunk mid-count wraps on the next edge
  always_comb begin
    wrap  = en_i && (cnt_q >= n_i - CNT_W'(1));
    cnt_d = clr_i ? '0 : !en_i ? cnt_q : wrap ? '0 : cnt_q + CNT_W'(1);
  end
  // count and tick registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap;
    end
  end
  assign cnt_o  = cnt_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/timebase_ctrl.sv
// timebase_ctrl: run/pause/step sequencing of the seconds, scan and blink timebase
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int unsigned      CNT_W    = 32,
  parameter logic [CNT_W-1:0] SEC_DIV  = 100_000_000,
  parameter logic [CNT_W-1:0] FAST_DIV = 1_000_000,
  parameter logic [CNT_W-1:0] SCAN_DIV = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             pause_req,
  input  logic             step_req,
  input  logic             fast,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick_sec,
  output logic             tick_scan,
  output logic             blink,
  output logic [1:0]       state
);
  state_t           state_q, state_d, ret_q, ret_d;
  logic [CNT_W-1:0] div_q, div_d, div_eff, sec_cnt;
  logic             blink_q, blink_d, run, xfer, sec_tick;
  // next state, period capture and blink toggle; STEP always returns where it came from
  always_comb begin
    run       = state_q == ST_RUN;
    cfg_ready = state_q == ST_IDLE || state_q == ST_PAUSE;
    xfer      = cfg_valid && cfg_ready;
    div_eff   = fast ? FAST_DIV : div_q;
    div_d     = !xfer ? div_q : cfg_div < CNT_W'(MIN_DIV) ? CNT_W'(MIN_DIV) : cfg_div;
    blink_d   = state_q == ST_IDLE ? 1'b0 :
                (run && (sec_cnt == (div_eff >> 1) - CNT_W'(1) || sec_cnt >= div_eff - CNT_W'(1))) ? ~blink_q : blink_q;
    state_d   = state_q == ST_STEP ? ret_q :
                run ? (pause_req ? ST_PAUSE : ST_RUN) :
                step_req ? ST_STEP :
                run_req ? ST_RUN : state_q;
    ret_d     = state_d == ST_STEP ? state_q : ret_q;
  end
  // FSM, period and blink registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      div_q   <= SEC_DIV;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      div_q   <= div_d;
      blink_q <= blink_d;
    end
  end
  tick_gen #(.CNT_W(CNT_W)) u_sec (
    .clk    (clk),
    .rst    (rst),
    .en_i   (run),
    .clr_i  (state_q == ST_IDLE || xfer),
    .n_i    (div_eff),
    .cnt_o  (sec_cnt),
    .tick_o (sec_tick)
  );
  tick_gen #(.CNT_W(CNT_W)) u_scan (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .n_i    (SCAN_DIV),
    .cnt_o  (),
    .tick_o (tick_scan)
  );
  assign tick_sec = sec_tick || state_q == ST_STEP;
  assign blink    = blink_q;
  assign state    = state_q;
endmodule

// File: tb/tb_timebase_ctrl.sv
// tb_timebase_ctrl: random request/config traffic checked against a cycle reference model
module tb_timebase_ctrl;
  localparam int W = 16, SEC = 10, FAST = 3, SCAN = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic run_req = 1'b0, pause_req = 1'b0, step_req = 1'b0, fast = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic cfg_ready, tick_sec, tick_scan, blink;
  logic [1:0] state;
  int n_chk = 0, n_pass = 0;
  int ms, mret, msec, mdiv, mcyc;
  bit mblink, mtick;

  timebase_ctrl #(.CNT_W(W), .SEC_DIV(W'(SEC)), .FAST_DIV(W'(FAST)), .SCAN_DIV(W'(SCAN))) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .pause_req(pause_req), .step_req(step_req),
    .fast(fast), .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
    .tick_sec(tick_sec), .tick_scan(tick_scan), .blink(blink), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ms = 0; mret = 0; msec = 0; mdiv = SEC; mcyc = 0; mblink = 0; mtick = 0;
  endtask

  task automatic check_outputs();
    chk("state", 32'(state), 32'(ms));
    chk("tick_sec", 32'(tick_sec), 32'(mtick || ms == 3));
    chk("tick_scan", 32'(tick_scan), 32'(mcyc > 0 && mcyc % SCAN == 0));
    chk("blink", 32'(blink), 32'(mblink));
    chk("cfg_ready", 32'(cfg_ready), 32'(ms == 0 || ms == 2));
  endtask

  task automatic model_step();
    int deff, ns;
    bit runs, xfer, wrap;
    deff = fast ? FAST : mdiv;
    runs = ms == 1;
    xfer = cfg_valid && (ms == 0 || ms == 2);
    wrap = runs && msec >= deff - 1;
    if (runs && (msec == deff / 2 - 1 || wrap)) mblink = !mblink;
    if (ms == 0) mblink = 0;
    mtick = wrap;
    if (ms == 0 || xfer) msec = 0;
    else if (runs) msec = wrap ? 0 : msec + 1;
    if (xfer) mdiv = cfg_div < 2 ? 2 : int'(cfg_div);
    if (ms == 3) ns = mret;
    else if (pause_req && ms == 1) ns = 2;
    else if (step_req && ms != 1) begin ns = 3; mret = ms; end
    else if (run_req && ms != 1) ns = 1;
    else ns = ms;
    ms = ns;
    mcyc++;
  endtask

  task automatic clear_inputs();
    run_req = 0; pause_req = 0; step_req = 0; fast = 0; cfg_valid = 0; cfg_div = '0;
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        clear_inputs();
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
      end
      run_req   = $urandom_range(99) < 8;
      pause_req = $urandom_range(99) < 3;
      step_req  = $urandom_range(99) < 4;
      if ($urandom_range(99) < 3) fast = !fast;
      cfg_valid = $urandom_range(9) == 0;
      cfg_div   = W'($urandom_range(12));
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
